alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the ALU interface: accepts one decoded ALU/branch request, drives mode/operands,
//  captures out/carry/zero into a local flag register and returns writeback data or a branch decision.
//  Sits between the instruction decoder and the alu instance; owns ALU mode sequencing and mode clear.
// PARAMETERS
//  DST_W    3   width of the destination register index (passed through to writeback)
//  DATA_W   8   operand/result width; fixed at 8 to match the alu; other values are unsupported
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       sequencer can accept; transfer when req_valid && req_ready
//  req_kind     in   2       K_OP=0 compute+writeback, K_CMP=1 compute flags only, K_JZ=2, K_JC=3
//  req_op       in   8       ALU mode code (`ALU_* from global_defines); ignored for K_JZ/K_JC
//  req_a/req_b  in   8       operands
//  req_dst      in   DST_W   writeback register index
//  alu_mode     out  8       mode to alu; `ALU_NON except during ISSUE
//  alu_a/alu_b  out  8       operands to alu, held from ISSUE through EXEC
//  alu_clr      out  1       drives the alu's synchronous clear input; returns the ALU mode to `ALU_NON
//  alu_out      in   8       alu result (combinational)
//  alu_carry    in   1       alu carry flag
//  alu_zero     in   1       alu zero flag
//  wb_valid     out  1       one-cycle writeback strobe
//  wb_data      out  8       writeback value
//  wb_dst       out  DST_W   writeback index
//  br_valid     out  1       one-cycle branch-decision strobe
//  br_taken     out  1       branch decision, valid with br_valid
//  resp_err     out  1       one-cycle strobe: K_OP/K_CMP with req_op == `ALU_NON or an unknown code
//  flag_c       out  1       held carry flag
//  flag_z       out  1       held zero flag
// BEHAVIOUR
//  Reset (reset_n low, any state): state=IDLE.
//   - req_ready=0 while reset_n is low; it rises in IDLE after release.
//   - alu_mode=`ALU_NON, alu_a=alu_b=0, alu_clr=1.
//   - wb_*, br_*, resp_err and flags are all 0.
//  FSM states: IDLE, ISSUE, EXEC, RESP. req_ready=1 only in IDLE; no request is accepted elsewhere.
//  Accept in IDLE, per req_kind:
//   - K_OP/K_CMP with a valid op: go to ISSUE; latch op/a/b/dst/kind.
//   - K_OP/K_CMP with an invalid op: go to RESP with err set.
//   - K_JZ/K_JC: go to RESP.
//  ISSUE: alu_mode=latched op, alu_a/alu_b driven, alu_clr=0; the alu latches the mode at the edge. Next state EXEC.
//  EXEC: alu_mode=`ALU_NON (alu keeps its mode), operands held, alu_clr=0.
//   - At the EXEC->RESP edge, capture alu_out into the result register.
//   - At the same edge, load alu_carry into flag_c and alu_zero into flag_z.
//  RESP: exactly one cycle with alu_clr=1, then IDLE. Strobes in RESP:
//   - K_OP: wb_valid=1.
//   - K_CMP: no strobe.
//   - err: resp_err=1; flags unchanged.
//   - K_JZ: br_valid=1, br_taken=flag_z.
//   - K_JC: br_valid=1, br_taken=flag_c.
//  Latency from the accept edge:
//   - K_OP: wb_valid in the 3rd cycle; one op per 4 cycles.
//   - K_JZ/K_JC: br_valid in the 1st cycle; one branch per 2 cycles.
//  Flags:
//   - Updated only by K_OP and K_CMP.
//   - Branches read the flag_c/flag_z values held at accept time.
//   - flag_c/flag_z stay stable between updates and are visible continuously.
//  alu_clr is also 1 in IDLE. It is never asserted in ISSUE, because clear would override the mode capture.
//  reset_n asserted mid-operation: abort immediately, no strobes, flags cleared; the alu is cleared via alu_clr.
//  req_* inputs are don't-care when not accepted. Holding req_valid high yields one accept per IDLE visit.
// STRUCTURE
//  Package tinymcu_pkg:
//   - req_kind_e {K_OP,K_CMP,K_JZ,K_JC}
//   - seq_state_e {IDLE,ISSUE,EXEC,RESP}
//   - function is_valid_alu_op(logic[7:0]) covering the eight `ALU_* codes.
//  Sub-module alu_flag_reg: async-reset C/Z register with load enable.
//  Everything else is a single always_ff FSM plus one always_comb output decode.
// TESTING
//  K_OP `ALU_ADD a=0x7F b=0x01 dst=2 -> wb_valid 3 cycles after accept, wb_data=0x80, wb_dst=2, flag_c=1, flag_z=0.
//  K_CMP `ALU_SUB 0x05,0x05, then K_JZ -> no wb_valid; flag_z=1; br_valid with br_taken=1 one cycle after JZ accept.
//  After reset, K_JC -> br_taken=0. Then `ALU_SHL a=0x81, then K_JC -> br_taken=1 (carry=a[7]).
//  K_OP with req_op=`ALU_NON -> resp_err one cycle after accept; no wb_valid; flags unchanged; alu_mode never leaves `ALU_NON.
//  reset_n low during EXEC -> all outputs 0 asynchronously, no wb_valid; req_ready=1 the cycle after release.
//  req_valid held high for 8 K_OP ADDs -> exactly 2 accepts; req_ready pattern 1,0,0,0,1,0,0,0; alu_clr never high in ISSUE.

Source files
------------

// File: rtl/tinymcu_pkg.sv
// Shared types and ALU mode codes for the tinymcu datapath.
package tinymcu_pkg;

  typedef enum logic [1:0] {K_OP = 2'd0, K_CMP = 2'd1, K_JZ = 2'd2, K_JC = 2'd3} req_kind_e;

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} seq_state_e;

  localparam logic [7:0] ALU_NON = 8'h00;
  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_AND = 8'h03;
  localparam logic [7:0] ALU_OR  = 8'h04;
  localparam logic [7:0] ALU_XOR = 8'h05;
  localparam logic [7:0] ALU_NOT = 8'h06;
  localparam logic [7:0] ALU_SHL = 8'h07;
  localparam logic [7:0] ALU_SHR = 8'h08;

  function automatic logic is_valid_alu_op(logic [7:0] op);
    logic ok;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_sequencer_flag_reg.sv
// Held carry/zero flags with load enable; cleared asynchronously by reset.
module alu_flag_reg (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic c_in,
  input  logic z_in,
  output logic flag_c,
  output logic flag_z
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (load) begin
      flag_c <= c_in;
      flag_z <= z_in;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator side of the ALU interface: sequences one request through the alu and
// returns writeback data, a branch decision or an error strobe.
module alu_sequencer
  import tinymcu_pkg::*;
#(
  parameter int unsigned DST_W  = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [7:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [DST_W-1:0]  req_dst,
  output logic [7:0]        alu_mode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_clr,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [DST_W-1:0]  wb_dst,
  output logic              br_valid,
  output logic              br_taken,
  output logic              resp_err,
  output logic              flag_c,
  output logic              flag_z
);

  seq_state_e        state_q, state_d;
  req_kind_e         kind_q;
  logic [7:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [DST_W-1:0]  dst_q;
  logic              err_q;
  logic              accept;
  logic              flag_load;

  assign flag_load = (state_q == EXEC);

  alu_flag_reg u_flag_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (flag_load),
    .c_in   (alu_carry),
    .z_in   (alu_zero),
    .flag_c (flag_c),
    .flag_z (flag_z)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      kind_q   <= K_OP;
      op_q     <= ALU_NON;
      a_q      <= '0;
      b_q      <= '0;
      dst_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q <= req_kind_e'(req_kind);
        op_q   <= req_op;
        a_q    <= req_a;
        b_q    <= req_b;
        dst_q  <= req_dst;
        err_q  <= (req_kind_e'(req_kind) inside {K_OP, K_CMP}) && !is_valid_alu_op(req_op);
      end
      if (flag_load) result_q <= alu_out;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    alu_mode  = ALU_NON;
    alu_a     = '0;
    alu_b     = '0;
    alu_clr   = 1'b0;
    wb_valid  = 1'b0;
    wb_data   = '0;
    wb_dst    = '0;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    resp_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        alu_clr   = 1'b1;
        req_ready = reset_n;
        if (req_valid && reset_n) begin
          accept = 1'b1;
          if ((req_kind_e'(req_kind) inside {K_OP, K_CMP}) && is_valid_alu_op(req_op)) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        alu_mode = op_q;
        alu_a    = a_q;
        alu_b    = b_q;
        state_d  = EXEC;
      end
      EXEC: begin
        // The alu keeps the mode it latched in ISSUE; only the operands stay on the bus.
        alu_a   = a_q;
        alu_b   = b_q;
        state_d = RESP;
      end
      RESP: begin
        alu_clr  = 1'b1;
        resp_err = err_q;
        wb_valid = (kind_q == K_OP) && !err_q;
        br_valid = (kind_q == K_JZ) || (kind_q == K_JC);
        br_taken = br_valid && ((kind_q == K_JZ) ? flag_z : flag_c);
        if (wb_valid) begin
          wb_data = result_q;
          wb_dst  = dst_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural alu attached.
module tb_alu_sequencer;
  import tinymcu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_kind;
  logic [7:0] req_op, req_a, req_b;
  logic [2:0] req_dst;
  logic [7:0] alu_mode, alu_a, alu_b, alu_out;
  logic       alu_clr, alu_carry, alu_zero;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic [2:0] wb_dst;
  logic       br_valid, br_taken, resp_err, flag_c, flag_z;

  int n_total = 0;
  int n_bad   = 0;
  logic m_c = 1'b0;
  logic m_z = 1'b0;
  logic [7:0] alu_m = 8'h00;

  alu_sequencer #(.DST_W(3), .DATA_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_kind (req_kind),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_dst  (req_dst),
    .alu_mode (alu_mode),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_clr  (alu_clr),
    .alu_out  (alu_out),
    .alu_carry(alu_carry),
    .alu_zero (alu_zero),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_dst   (wb_dst),
    .br_valid (br_valid),
    .br_taken (br_taken),
    .resp_err (resp_err),
    .flag_c   (flag_c),
    .flag_z   (flag_z)
  );

  always #5 clk = ~clk;

  // Returns {carry, zero, out}. ADD carry is the signed-overflow indication, SUB carry is borrow.
  function automatic logic [9:0] alu_fn(logic [7:0] op, logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    case (op)
      ALU_ADD: begin r = a + b; c = (a[7] == b[7]) && (r[7] != a[7]); end
      ALU_SUB: begin r = a - b; c = (a < b); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOT: r = ~a;
      ALU_SHL: begin r = a << 1; c = a[7]; end
      ALU_SHR: begin r = a >> 1; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  always_ff @(posedge clk) begin
    if (alu_clr) alu_m <= ALU_NON;
    else if (alu_mode != ALU_NON) alu_m <= alu_mode;
  end

  assign {alu_carry, alu_zero, alu_out} = alu_fn(alu_m, alu_a, alu_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && alu_mode != ALU_NON) check_eq("clr_in_issue", alu_clr, 0);
  end

  // Issues one request from IDLE (called #1 after a posedge) and checks every cycle until IDLE.
  task automatic do_txn(input logic [1:0] kind, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] dst);
    logic       compute, ok;
    logic [9:0] r;
    compute = (kind == 2'd0) || (kind == 2'd1);
    ok      = (op >= 8'd1) && (op <= 8'd8);
    check_eq("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_kind = kind; req_op = op; req_a = a; req_b = b; req_dst = dst;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_kind = 2'($urandom); req_op = 8'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    if (!compute || !ok) begin
      check_eq("br_valid", br_valid, !compute);
      check_eq("br_taken", br_taken, !compute && ((kind == 2'd2) ? m_z : m_c));
      check_eq("resp_err", resp_err, compute);
      check_eq("wb_none", wb_valid, 0);
      check_eq("mode_non", alu_mode, ALU_NON);
      check_eq("clr_resp", alu_clr, 1);
      check_eq("ready_busy", req_ready, 0);
      @(posedge clk); #1;
    end else begin
      check_eq("issue_mode", alu_mode, op);
      check_eq("issue_a", alu_a, a);
      check_eq("issue_b", alu_b, b);
      check_eq("issue_clr", alu_clr, 0);
      check_eq("ready_busy", req_ready, 0);
      @(posedge clk); #1;
      check_eq("exec_mode", alu_mode, ALU_NON);
      check_eq("exec_a", alu_a, a);
      check_eq("exec_clr", alu_clr, 0);
      check_eq("exec_wb", wb_valid, 0);
      @(posedge clk); #1;
      r = alu_fn(op, a, b);
      m_c = r[9];
      m_z = r[8];
      check_eq("wb_valid", wb_valid, kind == 2'd0);
      check_eq("wb_data", wb_data, (kind == 2'd0) ? r[7:0] : 8'h00);
      check_eq("wb_dst", wb_dst, (kind == 2'd0) ? dst : 3'd0);
      check_eq("resp_br", br_valid, 0);
      check_eq("resp_clr", alu_clr, 1);
      @(posedge clk); #1;
    end
    check_eq("flag_c", flag_c, m_c);
    check_eq("flag_z", flag_z, m_z);
  endtask

  initial begin
    int acc, wbn;
    logic [7:0] rop;
    reset_n = 1'b0; req_valid = 1'b0; req_kind = 2'd0; req_op = 8'h00;
    req_a = 8'h00; req_b = 8'h00; req_dst = 3'd0;
    #12;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_mode", alu_mode, ALU_NON);
    check_eq("rst_a", alu_a, 0);
    check_eq("rst_clr", alu_clr, 1);
    check_eq("rst_wb", wb_valid, 0);
    check_eq("rst_flags", {flag_c, flag_z}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    do_txn(2'd3, 8'h00, 8'h00, 8'h00, 3'd0);
    do_txn(2'd0, ALU_ADD, 8'h7F, 8'h01, 3'd2);
    check_eq("add_c", flag_c, 1);
    do_txn(2'd1, ALU_SUB, 8'h05, 8'h05, 3'd1);
    check_eq("cmp_z", flag_z, 1);
    do_txn(2'd2, 8'h00, 8'h00, 8'h00, 3'd0);
    do_txn(2'd0, ALU_SHL, 8'h81, 8'h00, 3'd4);
    do_txn(2'd3, 8'h00, 8'h00, 8'h00, 3'd0);

    // Abort during EXEC with carry set.
    req_valid = 1'b1; req_kind = 2'd0; req_op = ALU_ADD; req_a = 8'h33; req_b = 8'h44;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_abort_a", alu_a, 8'h33);
    reset_n = 1'b0; #1;
    m_c = 1'b0; m_z = 1'b0;
    check_eq("abort_ready", req_ready, 0);
    check_eq("abort_wb", wb_valid, 0);
    check_eq("abort_a", alu_a, 0);
    check_eq("abort_clr", alu_clr, 1);
    check_eq("abort_flags", {flag_c, flag_z}, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("abort_wb_hold", wb_valid, 0);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", req_ready, 1);

    do_txn(2'd0, ALU_ADD, 8'h01, 8'h01, 3'd3);
    do_txn(2'd0, ALU_NON, 8'h12, 8'h34, 3'd5);

    // Held request: one accept per IDLE visit.
    acc = 0; wbn = 0;
    req_valid = 1'b1; req_kind = 2'd0; req_op = ALU_ADD; req_a = 8'h10; req_b = 8'h20;
    req_dst = 3'd6;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("held_ready", req_ready, (i % 4) == 0);
      if (req_ready) acc++;
      @(posedge clk); #1;
      if (wb_valid) wbn++;
    end
    req_valid = 1'b0;
    m_c = 1'b0; m_z = 1'b0;
    check_eq("held_accepts", acc, 2);
    check_eq("held_wb", wbn, 2);

    for (int n = 0; n < 60; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(0, 8));
      do_txn(2'($urandom), rop, 8'($urandom), 8'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
